// File: rtl/marker_pkg.sv
// Shared constants and types for the loopback marker framing (TX generator and RX demux).
package marker_pkg;

  // K28.0 byte that opens a marker frame (low byte, RX_KCHAR == 2'b01)
  localparam logic [7:0]  MARKER_K   = 8'h1C;
  // Idle word used wherever a marker word is removed from the stream
  localparam logic [15:0] IDLE_DATA  = 16'h50BC;
  localparam logic [1:0]  IDLE_KCHAR = 2'b01;

  typedef enum logic {
    ST_IDLE,
    ST_PAYLOAD
  } state_e;

  // A marker K word: valid, only the low byte is a K char, and that byte is MARKER_K
  function automatic logic is_marker_k(input logic        valid,
                                       input logic [15:0] data,
                                       input logic [1:0]  kchar);
    return valid && (kchar == 2'b01) && (data[7:0] == MARKER_K);
  endfunction

endpackage

// File: rtl/marker_rx_demux_sat_cnt16.sv
// 16-bit event counter with synchronous clear (dominant over increment) and saturation at 16'hFFFF.
module sat_cnt16 (
  input  logic        clk,
  input  logic        srst,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear first, then increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 16'h0000;
    end else if (inc_i && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/marker_rx_demux.sv
// RX marker demux: removes 2-word loopback marker frames from the PCS receive stream,
// replaces them with IDLE, reports type/sequence and counts frames and errors.
module marker_rx_demux
  import marker_pkg::*;
(
  input  logic        RX_CLK,
  input  logic        RESET,
  input  logic        RX_VALID,
  input  logic [15:0] RX_DATA,
  input  logic [1:0]  RX_KCHAR,
  input  logic        MARKER_EN,
  input  logic        CNT_CLEAR,
  output logic [15:0] FIBER_DATA,
  output logic [1:0]  FIBER_KCHAR,
  output logic        MARKER_VALID,
  output logic [7:0]  MARKER_TYPE,
  output logic [15:0] MARKER_SEQ,
  output logic        MARKER_SEQ_ERR,
  output logic [15:0] MARKER_CNT,
  output logic [15:0] MARKER_ERR_CNT
);

  state_e      state_q;
  logic        seq_ref_ok_q;
  logic [7:0]  type_pend_q;     // type of the frame currently in flight
  logic [15:0] fiber_data_q;
  logic [1:0]  fiber_kchar_q;
  logic        marker_valid_q;
  logic [7:0]  marker_type_q;
  logic [15:0] marker_seq_q;    // doubles as the sequence reference
  logic        seq_err_q;

  logic        mk_word;
  logic        payload_word;
  logic        abort_word;
  logic [15:0] seq_expect;
  logic        seq_err_now;
  logic        err_inc;

  // Word classification for the current cycle and the sequence continuity check
  always_comb begin
    mk_word      = is_marker_k(RX_VALID, RX_DATA, RX_KCHAR);
    payload_word = RX_VALID && (state_q == ST_PAYLOAD) && (RX_KCHAR == 2'b00);
    abort_word   = RX_VALID && (state_q == ST_PAYLOAD) && (RX_KCHAR != 2'b00);
    seq_expect   = marker_seq_q + 16'd1;
    seq_err_now  = payload_word && seq_ref_ok_q && (RX_DATA != seq_expect);
    err_inc      = seq_err_now || abort_word;
  end

  // Frame FSM with registered stream and marker-report outputs
  always_ff @(posedge RX_CLK) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      seq_ref_ok_q   <= 1'b0;
      type_pend_q    <= 8'h00;
      fiber_data_q   <= IDLE_DATA;
      fiber_kchar_q  <= IDLE_KCHAR;
      marker_valid_q <= 1'b0;
      marker_type_q  <= 8'h00;
      marker_seq_q   <= 16'h0000;
      seq_err_q      <= 1'b0;
    end else begin
      marker_valid_q <= 1'b0;
      seq_err_q      <= 1'b0;
      if (!RX_VALID) begin
        // Lost alignment: emit idle, drop any partial frame, forget the reference
        fiber_data_q  <= IDLE_DATA;
        fiber_kchar_q <= IDLE_KCHAR;
        state_q       <= ST_IDLE;
        seq_ref_ok_q  <= 1'b0;
      end else begin
        fiber_data_q  <= RX_DATA;
        fiber_kchar_q <= RX_KCHAR;
        case (state_q)
          ST_IDLE: begin
            if (mk_word && MARKER_EN) begin
              type_pend_q   <= RX_DATA[15:8];
              fiber_data_q  <= IDLE_DATA;
              fiber_kchar_q <= IDLE_KCHAR;
              state_q       <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (payload_word) begin
              fiber_data_q   <= IDLE_DATA;
              fiber_kchar_q  <= IDLE_KCHAR;
              marker_valid_q <= 1'b1;
              marker_type_q  <= type_pend_q;
              marker_seq_q   <= RX_DATA;
              seq_err_q      <= seq_err_now;
              seq_ref_ok_q   <= 1'b1;
              state_q        <= ST_IDLE;
            end else if (mk_word) begin
              // Aborting K word is forwarded but still opens a new frame
              type_pend_q <= RX_DATA[15:8];
              state_q     <= ST_PAYLOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  sat_cnt16 u_marker_cnt (
    .clk   (RX_CLK),
    .srst  (RESET),
    .clr_i (CNT_CLEAR),
    .inc_i (payload_word),
    .cnt_o (MARKER_CNT)
  );

  sat_cnt16 u_err_cnt (
    .clk   (RX_CLK),
    .srst  (RESET),
    .clr_i (CNT_CLEAR),
    .inc_i (err_inc),
    .cnt_o (MARKER_ERR_CNT)
  );

  assign FIBER_DATA     = fiber_data_q;
  assign FIBER_KCHAR    = fiber_kchar_q;
  assign MARKER_VALID   = marker_valid_q;
  assign MARKER_TYPE    = marker_type_q;
  assign MARKER_SEQ     = marker_seq_q;
  assign MARKER_SEQ_ERR = seq_err_q;

endmodule

// File: tb/tb_marker_rx_demux.sv
// Directed bench for marker_rx_demux: vector table plus hand-written reset/saturation sequences.
module tb_marker_rx_demux;

  logic        RX_CLK = 1'b0;
  logic        RESET;
  logic        RX_VALID;
  logic [15:0] RX_DATA;
  logic [1:0]  RX_KCHAR;
  logic        MARKER_EN;
  logic        CNT_CLEAR;
  logic [15:0] FIBER_DATA;
  logic [1:0]  FIBER_KCHAR;
  logic        MARKER_VALID;
  logic [7:0]  MARKER_TYPE;
  logic [15:0] MARKER_SEQ;
  logic        MARKER_SEQ_ERR;
  logic [15:0] MARKER_CNT;
  logic [15:0] MARKER_ERR_CNT;

  int checks = 0;
  int errors = 0;

  always #5 RX_CLK = ~RX_CLK;

  marker_rx_demux dut (
    .RX_CLK         (RX_CLK),
    .RESET          (RESET),
    .RX_VALID       (RX_VALID),
    .RX_DATA        (RX_DATA),
    .RX_KCHAR       (RX_KCHAR),
    .MARKER_EN      (MARKER_EN),
    .CNT_CLEAR      (CNT_CLEAR),
    .FIBER_DATA     (FIBER_DATA),
    .FIBER_KCHAR    (FIBER_KCHAR),
    .MARKER_VALID   (MARKER_VALID),
    .MARKER_TYPE    (MARKER_TYPE),
    .MARKER_SEQ     (MARKER_SEQ),
    .MARKER_SEQ_ERR (MARKER_SEQ_ERR),
    .MARKER_CNT     (MARKER_CNT),
    .MARKER_ERR_CNT (MARKER_ERR_CNT)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic [1:0]  k;
    logic        en;
    logic        clr;
    logic [15:0] efd;
    logic [1:0]  efk;
    logic        emv;
    logic [7:0]  etype;
    logic [15:0] eseq;
    logic        eserr;
    logic [15:0] ecnt;
    logic [15:0] eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic [1:0] k,
                              input logic en, input logic clr,
                              input logic [15:0] efd, input logic [1:0] efk, input logic emv,
                              input logic [7:0] etype, input logic [15:0] eseq, input logic eserr,
                              input logic [15:0] ecnt, input logic [15:0] eerr);
    vec_t t;
    t.v = v; t.d = d; t.k = k; t.en = en; t.clr = clr;
    t.efd = efd; t.efk = efk; t.emv = emv; t.etype = etype; t.eseq = eseq;
    t.eserr = eserr; t.ecnt = ecnt; t.eerr = eerr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] efd, input logic [1:0] efk,
                           input logic emv, input logic [7:0] etype, input logic [15:0] eseq,
                           input logic eserr, input logic [15:0] ecnt, input logic [15:0] eerr);
    chk({tag, " FIBER_DATA"},     FIBER_DATA,             efd);
    chk({tag, " FIBER_KCHAR"},    16'(FIBER_KCHAR),       16'(efk));
    chk({tag, " MARKER_VALID"},   16'(MARKER_VALID),      16'(emv));
    chk({tag, " MARKER_TYPE"},    16'(MARKER_TYPE),       16'(etype));
    chk({tag, " MARKER_SEQ"},     MARKER_SEQ,             eseq);
    chk({tag, " MARKER_SEQ_ERR"}, 16'(MARKER_SEQ_ERR),    16'(eserr));
    chk({tag, " MARKER_CNT"},     MARKER_CNT,             ecnt);
    chk({tag, " MARKER_ERR_CNT"}, MARKER_ERR_CNT,         eerr);
  endtask

  // Drive one word, clock it, then sample #1 after the edge
  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] k,
                       input logic en, input logic clr);
    RX_VALID  = v;
    RX_DATA   = d;
    RX_KCHAR  = k;
    MARKER_EN = en;
    CNT_CLEAR = clr;
    @(posedge RX_CLK);
    #1;
  endtask

  initial begin
    // Test 1: plain traffic
    tbl.push_back(mk(1, 16'h1234, 2'b00, 1, 0, 16'h1234, 2'b00, 0, 8'h00, 16'h0000, 0, 16'd0, 16'd0));
    tbl.push_back(mk(1, 16'hABCD, 2'b00, 1, 0, 16'hABCD, 2'b00, 0, 8'h00, 16'h0000, 0, 16'd0, 16'd0));
    // Test 2: two frames of type 07, seq 5 then 6
    tbl.push_back(mk(1, 16'h071C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h00, 16'h0000, 0, 16'd0, 16'd0));
    tbl.push_back(mk(1, 16'h0005, 2'b00, 1, 0, 16'h50BC, 2'b01, 1, 8'h07, 16'h0005, 0, 16'd1, 16'd0));
    tbl.push_back(mk(1, 16'h071C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h07, 16'h0005, 0, 16'd1, 16'd0));
    tbl.push_back(mk(1, 16'h0006, 2'b00, 1, 0, 16'h50BC, 2'b01, 1, 8'h07, 16'h0006, 0, 16'd2, 16'd0));
    // Test 3: invalid word clears the reference, then FFFF -> 0000 (legal) -> 0005 (error)
    tbl.push_back(mk(0, 16'h1C1C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h07, 16'h0006, 0, 16'd2, 16'd0));
    tbl.push_back(mk(1, 16'h091C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h07, 16'h0006, 0, 16'd2, 16'd0));
    tbl.push_back(mk(1, 16'hFFFF, 2'b00, 1, 0, 16'h50BC, 2'b01, 1, 8'h09, 16'hFFFF, 0, 16'd3, 16'd0));
    tbl.push_back(mk(1, 16'h091C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h09, 16'hFFFF, 0, 16'd3, 16'd0));
    tbl.push_back(mk(1, 16'h0000, 2'b00, 1, 0, 16'h50BC, 2'b01, 1, 8'h09, 16'h0000, 0, 16'd4, 16'd0));
    tbl.push_back(mk(1, 16'h091C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h09, 16'h0000, 0, 16'd4, 16'd0));
    tbl.push_back(mk(1, 16'h0005, 2'b00, 1, 0, 16'h50BC, 2'b01, 1, 8'h09, 16'h0005, 1, 16'd5, 16'd1));
    tbl.push_back(mk(1, 16'h1111, 2'b00, 1, 0, 16'h1111, 2'b00, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd1));
    // Test 4: aborts (idle K word, then a non-marker K word), stream returns to IDLE
    tbl.push_back(mk(1, 16'h0A1C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd1));
    tbl.push_back(mk(1, 16'h50BC, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd2));
    tbl.push_back(mk(1, 16'h2222, 2'b00, 1, 0, 16'h2222, 2'b00, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd2));
    tbl.push_back(mk(1, 16'h0B1C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd2));
    tbl.push_back(mk(1, 16'hF7F7, 2'b11, 1, 0, 16'hF7F7, 2'b11, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd3));
    tbl.push_back(mk(1, 16'h0003, 2'b00, 1, 0, 16'h0003, 2'b00, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd3));
    // Test 5: MARKER_EN=0 passes the frame; EN dropping mid-frame still strips it
    tbl.push_back(mk(1, 16'h071C, 2'b01, 0, 0, 16'h071C, 2'b01, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd3));
    tbl.push_back(mk(1, 16'h0006, 2'b00, 0, 0, 16'h0006, 2'b00, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd3));
    tbl.push_back(mk(1, 16'h0C1C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h09, 16'h0005, 0, 16'd5, 16'd3));
    tbl.push_back(mk(1, 16'h0006, 2'b00, 0, 0, 16'h50BC, 2'b01, 1, 8'h0C, 16'h0006, 0, 16'd6, 16'd3));
    // Test 6c: CNT_CLEAR together with an erroring frame -> both counters 0
    tbl.push_back(mk(1, 16'h0D1C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h0C, 16'h0006, 0, 16'd6, 16'd3));
    tbl.push_back(mk(1, 16'h0009, 2'b00, 1, 1, 16'h50BC, 2'b01, 1, 8'h0D, 16'h0009, 1, 16'd0, 16'd0));
    tbl.push_back(mk(1, 16'h0D1C, 2'b01, 1, 0, 16'h50BC, 2'b01, 0, 8'h0D, 16'h0009, 0, 16'd0, 16'd0));
    tbl.push_back(mk(1, 16'h000A, 2'b00, 1, 0, 16'h50BC, 2'b01, 1, 8'h0D, 16'h000A, 0, 16'd1, 16'd0));

    // Reset state
    RESET = 1'b1;
    drive(0, 16'h0000, 2'b00, 0, 0);
    drive(0, 16'h0000, 2'b00, 0, 0);
    check_all("reset", 16'h50BC, 2'b01, 0, 8'h00, 16'h0000, 0, 16'd0, 16'd0);
    RESET = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].en, tbl[i].clr);
      $display("vec %0d: in=%h/%b v=%b en=%b clr=%b -> fiber=%h/%b mv=%b type=%h seq=%h serr=%b cnt=%0d err=%0d",
               i, tbl[i].d, tbl[i].k, tbl[i].v, tbl[i].en, tbl[i].clr, FIBER_DATA, FIBER_KCHAR,
               MARKER_VALID, MARKER_TYPE, MARKER_SEQ, MARKER_SEQ_ERR, MARKER_CNT, MARKER_ERR_CNT);
      check_all($sformatf("vec%0d", i), tbl[i].efd, tbl[i].efk, tbl[i].emv, tbl[i].etype,
                tbl[i].eseq, tbl[i].eserr, tbl[i].ecnt, tbl[i].eerr);
    end

    // Reset while in PAYLOAD: everything back to reset values, partial frame discarded
    drive(1, 16'h0E1C, 2'b01, 1, 0);
    RESET = 1'b1;
    drive(1, 16'h000B, 2'b00, 1, 0);
    check_all("reset_mid", 16'h50BC, 2'b01, 0, 8'h00, 16'h0000, 0, 16'd0, 16'd0);
    $display("seq reset_mid: fiber=%h/%b cnt=%0d err=%0d", FIBER_DATA, FIBER_KCHAR, MARKER_CNT, MARKER_ERR_CNT);
    RESET = 1'b0;
    drive(1, 16'h000C, 2'b00, 1, 0);
    check_all("post_reset", 16'h000C, 2'b00, 0, 8'h00, 16'h0000, 0, 16'd0, 16'd0);
    drive(1, 16'h0F1C, 2'b01, 1, 0);
    drive(1, 16'h0010, 2'b00, 1, 0);
    check_all("first_after_reset", 16'h50BC, 2'b01, 1, 8'h0F, 16'h0010, 0, 16'd1, 16'd0);
    $display("seq post_reset frame: type=%h seq=%h serr=%b cnt=%0d", MARKER_TYPE, MARKER_SEQ, MARKER_SEQ_ERR, MARKER_CNT);

    // Saturation: back-to-back marker K words abort one frame per cycle
    drive(1, 16'h071C, 2'b01, 1, 0);
    for (int i = 1; i < 65535; i++) drive(1, 16'h071C, 2'b01, 1, 0);
    chk("err_cnt_pre_sat", MARKER_ERR_CNT, 16'hFFFE);
    drive(1, 16'h071C, 2'b01, 1, 0);
    chk("err_cnt_sat", MARKER_ERR_CNT, 16'hFFFF);
    drive(1, 16'h071C, 2'b01, 1, 0);
    drive(1, 16'h071C, 2'b01, 1, 0);
    chk("err_cnt_hold", MARKER_ERR_CNT, 16'hFFFF);
    chk("abort_fwd_data", FIBER_DATA, 16'h071C);
    chk("abort_cnt_unchanged", MARKER_CNT, 16'd1);
    $display("seq saturation: err=%h cnt=%0d fiber=%h", MARKER_ERR_CNT, MARKER_CNT, FIBER_DATA);

    // Clear from saturation, with RX_VALID low
    drive(0, 16'h0000, 2'b00, 1, 1);
    chk("clear_err", MARKER_ERR_CNT, 16'd0);
    chk("clear_cnt", MARKER_CNT, 16'd0);
    chk("invalid_fiber", FIBER_DATA, 16'h50BC);
    $display("seq clear: err=%0d cnt=%0d", MARKER_ERR_CNT, MARKER_CNT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
